// File: rtl/reward_engine.sv
// reward_engine: scans the neighbor table for the best next hop and issues one reward packet.
// Optional build macro REWARD_LOWE_GUARD_EN excludes neighbors whose energy is below LOW_E_THRESH.
module reward_engine #(
    parameter int WORD_WIDTH = 16,
    parameter int NT_DEPTH = 32,
    parameter int ENERGY_SHIFT = 4,
    parameter logic [WORD_WIDTH-1:0] LOW_E_THRESH = 'h0100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WORD_WIDTH-1:0]         myNodeID,
    input  logic [WORD_WIDTH-1:0]         myEnergy,
    input  logic [$clog2(NT_DEPTH):0]     neighborCount,
    output logic [$clog2(NT_DEPTH)-1:0]   nTableIndex_reward,
    input  logic [WORD_WIDTH-1:0]         mNodeID,
    input  logic [WORD_WIDTH-1:0]         mNodeQValue,
    input  logic [WORD_WIDTH-1:0]         mNodeEnergy,
    input  logic                          okToSend,
    output logic [WORD_WIDTH-1:0]         rSourceID,
    output logic [WORD_WIDTH-1:0]         rQValue,
    output logic [WORD_WIDTH-1:0]         rEnergyLeft,
    output logic [WORD_WIDTH-1:0]         rDestinationID,
    output logic [2:0]                    rPacketType,
    output logic                          pktValid,
    output logic                          busy,
    output logic                          noRoute,
    output logic                          reward_done
);
    localparam int AW = $clog2(NT_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, PACK, WAIT_TX, DONE} state_t;

    state_t                state, next;
    logic [CW-1:0]         n, n_sel;
    logic                  rd_valid, best_found, eligible, better, found_any, last, start, no_route_set;
    logic [WORD_WIDTH-1:0] my_id, my_energy, best_id, best_score, score;
    logic [WORD_WIDTH:0]   sum;

    assign start        = (state == IDLE) && en;
    assign n_sel        = (neighborCount > CW'(NT_DEPTH)) ? CW'(NT_DEPTH) : neighborCount;
    assign last         = {1'b0, nTableIndex_reward} == n - CW'(1);
    assign sum          = {1'b0, mNodeQValue} + {1'b0, mNodeEnergy >> ENERGY_SHIFT};
    assign score        = sum[WORD_WIDTH] ? '1 : sum[WORD_WIDTH-1:0];
    assign better       = rd_valid && eligible && (!best_found || score > best_score);
    assign found_any    = best_found || better;
    assign no_route_set = (start && n_sel == '0) || (state == DRAIN && !found_any);
    assign pktValid     = state == WAIT_TX;
    assign busy         = state != IDLE;
    assign reward_done  = state == DONE;

`ifdef REWARD_LOWE_GUARD_EN
    assign eligible = mNodeEnergy >= LOW_E_THRESH;
`else
    // Every entry qualifies; the threshold term is kept so both builds reference it.
    assign eligible = (mNodeEnergy >= LOW_E_THRESH) | 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end

    // Next-state logic; DRAIN looks at the last entry being evaluated this cycle.
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (en) next = (n_sel != '0) ? SCAN : DONE;
            SCAN:    if (last) next = DRAIN;
            DRAIN:   next = found_any ? PACK : DONE;
            PACK:    next = WAIT_TX;
            WAIT_TX: if (okToSend) next = DONE;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Address sequencing, best-entry tracking and packet field registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n                  <= '0;
            nTableIndex_reward <= '0;
            rd_valid           <= 1'b0;
            my_id              <= '0;
            my_energy          <= '0;
            best_found         <= 1'b0;
            best_id            <= '0;
            best_score         <= '0;
            rSourceID          <= '0;
            rQValue            <= '0;
            rEnergyLeft        <= '0;
            rDestinationID     <= '0;
            rPacketType        <= '0;
            noRoute            <= 1'b0;
        end else begin
            rd_valid <= state == SCAN;
            if (start) begin
                n                  <= n_sel;
                my_id              <= myNodeID;
                my_energy          <= myEnergy;
                nTableIndex_reward <= '0;
                best_found         <= 1'b0;
                best_id            <= '0;
                best_score         <= '0;
                noRoute            <= 1'b0;
            end
            if (state == SCAN && !last) nTableIndex_reward <= nTableIndex_reward + AW'(1);
            if (better) begin
                best_found <= 1'b1;
                best_id    <= mNodeID;
                best_score <= score;
            end
            if (no_route_set) begin
                noRoute        <= 1'b1;
                rDestinationID <= '1;
                rQValue        <= '0;
                rPacketType    <= '0;
            end
            if (state == PACK) begin
                rSourceID      <= my_id;
                rEnergyLeft    <= my_energy;
                rDestinationID <= best_id;
                rQValue        <= best_score >> 1;
                rPacketType    <= 3'b011;
            end
        end
    end
endmodule

// File: tb/tb_reward_engine.sv
// tb_reward_engine: scoreboard bench for reward_engine with a modelled neighbor table.
module tb_reward_engine;
    typedef struct packed {
        logic        nr;
        logic [15:0] dest;
        logic [15:0] q;
        logic [15:0] src;
        logic [15:0] egy;
    } exp_t;

    logic        clk = 0, rst = 1, en = 0, okToSend = 0;
    logic [15:0] myNodeID = 0, myEnergy = 0;
    logic [5:0]  neighborCount = 0;
    logic [4:0]  nTableIndex_reward;
    logic [15:0] mNodeID = 0, mNodeQValue = 0, mNodeEnergy = 0;
    logic [15:0] rSourceID, rQValue, rEnergyLeft, rDestinationID;
    logic [2:0]  rPacketType;
    logic        pktValid, busy, noRoute, reward_done;

    logic [15:0] t_id [32];
    logic [15:0] t_q  [32];
    logic [15:0] t_e  [32];
    exp_t        sb[$];
    int          n_checks = 0, n_fail = 0;

    reward_engine dut (
        .clk(clk), .rst(rst), .en(en), .myNodeID(myNodeID), .myEnergy(myEnergy),
        .neighborCount(neighborCount), .nTableIndex_reward(nTableIndex_reward),
        .mNodeID(mNodeID), .mNodeQValue(mNodeQValue), .mNodeEnergy(mNodeEnergy),
        .okToSend(okToSend), .rSourceID(rSourceID), .rQValue(rQValue),
        .rEnergyLeft(rEnergyLeft), .rDestinationID(rDestinationID),
        .rPacketType(rPacketType), .pktValid(pktValid), .busy(busy),
        .noRoute(noRoute), .reward_done(reward_done)
    );

    always #5 clk = ~clk;

    // Table read data is valid one cycle after the address.
    always @(posedge clk) begin
        mNodeID     <= t_id[nTableIndex_reward];
        mNodeQValue <= t_q[nTableIndex_reward];
        mNodeEnergy <= t_e[nTableIndex_reward];
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic exp_t model(input int cnt, input logic [15:0] src, input logic [15:0] egy);
        exp_t        r;
        int          n = (cnt > 32) ? 32 : cnt;
        logic        found = 0, elig;
        logic [16:0] s;
        logic [15:0] best = 0, bid = 0;
        for (int i = 0; i < n; i++) begin
            s = {1'b0, t_q[i]} + {1'b0, t_e[i] >> 4};
            if (s > 17'h0FFFF) s = 17'h0FFFF;
`ifdef REWARD_LOWE_GUARD_EN
            elig = t_e[i] >= 16'h0100;
`else
            elig = 1'b1;
`endif
            if (elig && (!found || s[15:0] > best)) begin
                found = 1;
                best = s[15:0];
                bid = t_id[i];
            end
        end
        r.nr = !found;
        r.dest = found ? bid : 16'hFFFF;
        r.q = found ? best >> 1 : 16'h0;
        r.src = src;
        r.egy = egy;
        return r;
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 32; i++) begin
            t_id[i] = 16'h0;
            t_q[i] = 16'h0;
            t_e[i] = 16'h0;
        end
    endtask

    task automatic set_entry(input int i, input logic [15:0] id, input logic [15:0] q, input logic [15:0] e);
        t_id[i] = id;
        t_q[i] = q;
        t_e[i] = e;
    endtask

    // Pulses en for one cycle; returns at the negedge after the accepting edge.
    task automatic start_op(input int cnt, input logic [15:0] id, input logic [15:0] egy, input bit push);
        if (push) sb.push_back(model(cnt, id, egy));
        @(negedge clk);
        neighborCount = 6'(cnt);
        myNodeID = id;
        myEnergy = egy;
        en = 1;
        @(negedge clk);
        en = 0;
        neighborCount = 6'd0;
    endtask

    task automatic wait_out(output int c);
        c = 0;
        while (!pktValid && !reward_done && c < 200) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic finish_op();
        if (pktValid) begin
            okToSend = 1;
            @(negedge clk);
            okToSend = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({busy, pktValid, noRoute, reward_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=0000", {busy, pktValid, noRoute, reward_done});
        end
        n_checks++;
        if ({rDestinationID, rQValue, rSourceID, rEnergyLeft} !== 64'h0 || rPacketType !== 3'b0 || nTableIndex_reward !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_fields got=%h/%h/%h/%h/%0d want=0", rDestinationID, rQValue, rSourceID, rEnergyLeft, rPacketType);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   c;
        clear_table();
        set_entry(0, 16'd5, 16'd10, 16'h0100);
        set_entry(1, 16'd7, 16'd20, 16'h0040);
        set_entry(2, 16'd9, 16'd15, 16'h0080);
        start_op(3, 16'h0042, 16'h1234, 1);
        wait_out(c);
        e = sb.pop_front();
        n_checks++;
        if (c !== 5) begin
            n_fail++;
            $display("FAIL basic_latency got=%0d want=5", c);
        end
        n_checks++;
        if ({pktValid, rDestinationID, rQValue} !== {1'b1, e.dest, e.q}) begin
            n_fail++;
            $display("FAIL basic_result got=%b/%h/%h want=1/%h/%h", pktValid, rDestinationID, rQValue, e.dest, e.q);
        end
        n_checks++;
        if ({rSourceID, rEnergyLeft, rPacketType} !== {e.src, e.egy, 3'b011}) begin
            n_fail++;
            $display("FAIL basic_fields got=%h/%h/%b want=%h/%h/011", rSourceID, rEnergyLeft, rPacketType, e.src, e.egy);
        end
        myNodeID = 16'hAAAA;
        myEnergy = 16'h5555;
        neighborCount = 6'd2;
        en = 1;
        @(negedge clk);
        en = 0;
        @(negedge clk);
        n_checks++;
        if ({pktValid, rSourceID, rDestinationID, rQValue, rEnergyLeft} !== {1'b1, e.src, e.dest, e.q, e.egy}) begin
            n_fail++;
            $display("FAIL wait_tx_hold got=%b/%h/%h/%h/%h want=1/%h/%h/%h/%h", pktValid, rSourceID, rDestinationID, rQValue, rEnergyLeft, e.src, e.dest, e.q, e.egy);
        end
        okToSend = 1;
        @(negedge clk);
        okToSend = 0;
        n_checks++;
        if ({reward_done, pktValid, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL done_pulse got=%b want=101", {reward_done, pktValid, busy});
        end
        @(negedge clk);
        n_checks++;
        if ({reward_done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_end got=%b want=00", {reward_done, busy});
        end
    endtask

    task automatic test_no_route();
        exp_t e;
        int   c;
        start_op(0, 16'h0011, 16'h0022, 1);
        wait_out(c);
        e = sb.pop_front();
        n_checks++;
        if (c !== 0) begin
            n_fail++;
            $display("FAIL noroute_latency got=%0d want=0", c);
        end
        n_checks++;
        if ({noRoute, pktValid, reward_done, rDestinationID, rQValue} !== {e.nr, 1'b0, 1'b1, e.dest, e.q}) begin
            n_fail++;
            $display("FAIL noroute_result got=%b%b%b/%h/%h want=%b01/%h/%h", noRoute, pktValid, reward_done, rDestinationID, rQValue, e.nr, e.dest, e.q);
        end
        finish_op();
        n_checks++;
        if ({noRoute, pktValid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL noroute_hold got=%b want=100", {noRoute, pktValid, busy});
        end
    endtask

    task automatic test_tie_sat();
        exp_t e;
        int   c;
        clear_table();
        set_entry(0, 16'd100, 16'h0000, 16'h0100);
        set_entry(1, 16'd101, 16'h0005, 16'h0100);
        set_entry(2, 16'd102, 16'h0010, 16'h0100);
        set_entry(3, 16'd103, 16'h0000, 16'h0100);
        set_entry(4, 16'd104, 16'h0000, 16'h0200);
        start_op(5, 16'h0001, 16'h0002, 1);
        wait_out(c);
        e = sb.pop_front();
        n_checks++;
        if (c >= 200 || {noRoute, pktValid, rDestinationID, rQValue} !== {e.nr, ~e.nr, e.dest, e.q}) begin
            n_fail++;
            $display("FAIL tie_result got=%b%b/%h/%h want=%b%b/%h/%h", noRoute, pktValid, rDestinationID, rQValue, e.nr, ~e.nr, e.dest, e.q);
        end
        finish_op();
        clear_table();
        set_entry(0, 16'h0033, 16'hFFF0, 16'h0200);
        start_op(1, 16'h0003, 16'h0004, 1);
        wait_out(c);
        e = sb.pop_front();
        n_checks++;
        if (c >= 200 || {noRoute, pktValid, rDestinationID, rQValue} !== {e.nr, ~e.nr, e.dest, e.q}) begin
            n_fail++;
            $display("FAIL sat_result got=%b%b/%h/%h want=%b%b/%h/%h", noRoute, pktValid, rDestinationID, rQValue, e.nr, ~e.nr, e.dest, e.q);
        end
        n_checks++;
        if (rQValue !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL sat_q got=%h want=7fff", rQValue);
        end
        finish_op();
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        int   c;
        clear_table();
        for (int i = 0; i < 20; i++) set_entry(i, 16'(200 + i), 16'(i), 16'h0100);
        start_op(20, 16'h0005, 16'h0006, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1;
        #1;
        n_checks++;
        if ({busy, pktValid, noRoute, reward_done, nTableIndex_reward} !== 9'h0 || {rDestinationID, rQValue} !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_scan_reset got=%b%b%b%b/%0d/%h/%h want=0", busy, pktValid, noRoute, reward_done, nTableIndex_reward, rDestinationID, rQValue);
        end
        @(negedge clk);
        clear_table();
        set_entry(0, 16'h0077, 16'h0008, 16'h0100);
        sb.push_back(model(1, 16'h0009, 16'h000A));
        rst = 0;
        neighborCount = 6'd1;
        myNodeID = 16'h0009;
        myEnergy = 16'h000A;
        en = 1;
        @(negedge clk);
        en = 0;
        neighborCount = 6'd0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_en_after_reset got=%b want=1", busy);
        end
        wait_out(c);
        e = sb.pop_front();
        n_checks++;
        if (c !== 3 || {noRoute, pktValid, rDestinationID, rQValue} !== {e.nr, ~e.nr, e.dest, e.q}) begin
            n_fail++;
            $display("FAIL post_reset_result got=%0d/%b%b/%h/%h want=3/%b%b/%h/%h", c, noRoute, pktValid, rDestinationID, rQValue, e.nr, ~e.nr, e.dest, e.q);
        end
        finish_op();
    endtask

    task automatic test_overflow_count();
        exp_t e;
        int   c;
        clear_table();
        for (int i = 0; i < 32; i++) set_entry(i, 16'(300 + i), 16'(i), 16'h0100);
        start_op(40, 16'h0021, 16'h0022, 1);
        wait_out(c);
        e = sb.pop_front();
        n_checks++;
        if (c !== 34) begin
            n_fail++;
            $display("FAIL overflow_latency got=%0d want=34", c);
        end
        n_checks++;
        if ({noRoute, pktValid, rDestinationID, rQValue} !== {e.nr, ~e.nr, e.dest, e.q}) begin
            n_fail++;
            $display("FAIL overflow_result got=%b%b/%h/%h want=%b%b/%h/%h", noRoute, pktValid, rDestinationID, rQValue, e.nr, ~e.nr, e.dest, e.q);
        end
        finish_op();
    endtask

    task automatic test_low_energy();
        exp_t e;
        int   c;
        clear_table();
        set_entry(0, 16'd40, 16'd1, 16'h00FF);
        set_entry(1, 16'd41, 16'd9, 16'h00FF);
        set_entry(2, 16'd42, 16'd3, 16'h00FF);
        set_entry(3, 16'd43, 16'd2, 16'h00FF);
        start_op(4, 16'h0031, 16'h0032, 1);
        wait_out(c);
        e = sb.pop_front();
        n_checks++;
        if (c >= 200 || {noRoute, pktValid, rDestinationID, rQValue} !== {e.nr, ~e.nr, e.dest, e.q}) begin
            n_fail++;
            $display("FAIL low_energy_result got=%b%b/%h/%h want=%b%b/%h/%h", noRoute, pktValid, rDestinationID, rQValue, e.nr, ~e.nr, e.dest, e.q);
        end
        finish_op();
    endtask

    initial begin
        clear_table();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 0;
        test_basic();
        test_no_route();
        test_tie_sat();
        test_reset_mid_scan();
        test_overflow_count();
        test_low_energy();
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
